// File: rtl/udp_pkg.sv
// udp_pkg: shared widths, FIFO entry layout and demux FSM states for the UDP receive path
package udp_pkg;
    localparam int UDP_WORD_W = 24;
    localparam int BYTES_PER_WORD = 3;
    localparam int LEN_W = 16;
    typedef struct packed {
        logic sof;
        logic eof;
        logic [UDP_WORD_W-1:0] data;
    } rx_entry_t;
    typedef enum logic [2:0] {IDLE, WORD, B0, B1, B2, DRAIN, DONE} rx_state_t;
endpackage

// File: rtl/udp_rx_demux_unpack_if.sv
// udp_rx_demux_unpack_if: receive word bus in, byte/word sink streams and status out
interface udp_rx_demux_unpack_if #(parameter int LEN_W = 16);
    import udp_pkg::*;
    logic sel_byte;
    logic [UDP_WORD_W-1:0] rx_data;
    logic rx_valid;
    logic rx_sof;
    logic rx_eof;
    logic [LEN_W-1:0] rx_len;
    logic [7:0] byte_data;
    logic byte_valid;
    logic byte_ready;
    logic byte_last;
    logic [UDP_WORD_W-1:0] word_data;
    logic word_valid;
    logic word_last;
    logic frame_done;
    logic [LEN_W-1:0] frame_count;
    logic overflow;
    logic len_err;
    logic err_clr;
    modport master (
        output sel_byte, rx_data, rx_valid, rx_sof, rx_eof, rx_len, byte_ready, err_clr,
        input byte_data, byte_valid, byte_last, word_data, word_valid, word_last,
        frame_done, frame_count, overflow, len_err
    );
    modport slave (
        input sel_byte, rx_data, rx_valid, rx_sof, rx_eof, rx_len, byte_ready, err_clr,
        output byte_data, byte_valid, byte_last, word_data, word_valid, word_last,
        frame_done, frame_count, overflow, len_err
    );
endinterface

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word-fall-through FIFO; mark_en sets MARK_BIT of the newest entry
module sync_fifo_fwft #(
    parameter int WIDTH = 26,
    parameter int AW = 4,
    parameter int MARK_BIT = WIDTH - 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic mark_en,
    input  logic rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic empty,
    output logic full
);
    logic [WIDTH-1:0] mem [2**AW];
    logic [AW:0] wr_ptr, rd_ptr;
    logic [AW-1:0] newest;
    assign newest = wr_ptr[AW-1:0] - AW'(1);
    assign empty = wr_ptr == rd_ptr;
    assign full = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) & (wr_ptr[AW] != rd_ptr[AW]);
    assign rd_data = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + {{AW{1'b0}}, wr_en};
            rd_ptr <= rd_ptr + {{AW{1'b0}}, rd_en};
        end
    end
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
        else if (mark_en) mem[newest][MARK_BIT] <= 1'b1;
    end
endmodule

// File: rtl/udp_rx_demux_unpack.sv
// udp_rx_demux_unpack: buffers received UDP words and routes each frame to a byte
// sink (MSB-first unpack, padding stripped by length) or a word pass-through sink.
module udp_rx_demux_unpack #(
    parameter int FIFO_AW = 4,
    parameter int LEN_W = 16
) (
    input logic clk,
    input logic reset_n,
    udp_rx_demux_unpack_if.slave bus
);
    import udp_pkg::*;
    rx_state_t state, state_n;
    rx_entry_t head;
    logic empty, full, in_frame, mode_r, sof_ok, wr_cand, wr, drop, pop;
    logic bv, acc, last, early, wv, ovf_r, lerr_r;
    logic [LEN_W-1:0] rem, cnt;
    // A new frame is only taken into an idle, empty pipe; anything else drops the whole frame.
    assign sof_ok = bus.rx_valid & bus.rx_sof & (state == IDLE) & empty;
    assign wr_cand = bus.rx_valid & (bus.rx_sof ? sof_ok : in_frame);
    assign wr = wr_cand & !full;
    assign drop = wr_cand & full;
    sync_fifo_fwft #(.WIDTH($bits(rx_entry_t)), .AW(FIFO_AW), .MARK_BIT(UDP_WORD_W)) u_fifo (
        .clk(clk),
        .reset_n(reset_n),
        .wr_en(wr),
        .wr_data({bus.rx_sof, bus.rx_eof, bus.rx_data}),
        .mark_en(drop),
        .rd_en(pop),
        .rd_data(head),
        .empty(empty),
        .full(full)
    );
    assign bv = (state inside {B0, B1, B2}) & !empty;
    assign acc = bv & bus.byte_ready;
    assign last = bv & ((rem == LEN_W'(1)) | ((state == B2) & head.eof));
    assign early = acc & (state == B2) & head.eof & (rem > LEN_W'(1));
    assign wv = (state == WORD) & !empty;
    always_comb begin
        state_n = state;
        pop = 1'b0;
        unique case (state)
            IDLE: if (!empty) begin
                pop = !head.sof;
                if (head.sof) state_n = !mode_r ? WORD : rem == '0 ? DRAIN : B0;
            end
            WORD, DRAIN: if (!empty) begin
                pop = 1'b1;
                if (head.eof) state_n = DONE;
            end
            B0, B1, B2: if (acc) begin
                pop = state == B2;
                state_n = last ? ((state == B2) & head.eof ? DONE : DRAIN)
                        : state == B0 ? B1 : state == B1 ? B2 : B0;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            in_frame <= 1'b0;
            mode_r <= 1'b0;
            rem <= '0;
            cnt <= '0;
            ovf_r <= 1'b0;
            lerr_r <= 1'b0;
        end else begin
            state <= state_n;
            if (bus.rx_valid) in_frame <= wr & !bus.rx_eof;
            if (sof_ok) begin
                mode_r <= bus.sel_byte;
                rem <= bus.rx_len;
            end else if (acc) rem <= rem - LEN_W'(1);
            cnt <= state == DONE ? '0 : cnt + LEN_W'(acc | wv);
            ovf_r <= drop | (bus.rx_valid & bus.rx_sof & !sof_ok) | (ovf_r & !bus.err_clr);
            lerr_r <= early | (lerr_r & !bus.err_clr);
        end
    end
    assign bus.byte_valid = bv;
    assign bus.byte_last = last;
    assign bus.byte_data = !bv ? '0 : state == B0 ? head.data[23:16]
                         : state == B1 ? head.data[15:8] : head.data[7:0];
    assign bus.word_valid = wv;
    assign bus.word_data = wv ? head.data : '0;
    assign bus.word_last = wv & head.eof;
    assign bus.frame_done = state == DONE;
    assign bus.frame_count = state == DONE ? cnt : '0;
    assign bus.overflow = ovf_r;
    assign bus.len_err = lerr_r;
endmodule

// File: tb/tb_udp_rx_demux_unpack.sv
// tb_udp_rx_demux_unpack: directed and randomized frames checked against a queue-based
// model of what each sink should deliver.
module tb_udp_rx_demux_unpack;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0, errors = 0, cyc = 0, rdy_mode = 0;
    int first_cyc = -1, last_w_cyc = -1, sof_cyc = 0, len = 0, n = 0;
    logic sel = 1'b0;
    logic stall_p = 1'b0;
    logic [7:0] prev_b = '0;
    logic [8:0] q_b[$];
    logic [24:0] q_w[$];
    logic [15:0] q_d[$];
    logic [23:0] words[$], saved[$];

    udp_rx_demux_unpack_if #(.LEN_W(16)) bus();
    udp_rx_demux_unpack #(.FIFO_AW(4), .LEN_W(16)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({bus.byte_data, bus.byte_valid, bus.byte_last, bus.word_data, bus.word_valid,
                    bus.word_last, bus.frame_done, bus.frame_count, bus.overflow, bus.len_err});
    endfunction

    always @(negedge clk) begin
        if (!reset_n) stall_p = 1'b0;
        else begin
            if (stall_p) check("byte_hold", 64'({bus.byte_valid, bus.byte_data}), 64'({1'b1, prev_b}));
            if ((bus.byte_valid | bus.word_valid) && first_cyc < 0) first_cyc = cyc;
            if (bus.byte_valid && bus.byte_ready) q_b.push_back({bus.byte_last, bus.byte_data});
            if (bus.word_valid) begin
                q_w.push_back({bus.word_last, bus.word_data});
                last_w_cyc = cyc;
            end
            if (bus.frame_done) q_d.push_back(bus.frame_count);
            stall_p = bus.byte_valid & !bus.byte_ready;
            prev_b = bus.byte_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        bus.byte_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ~bus.byte_ready
                       : rdy_mode == 2 ? 1'($urandom) : 1'b0;
    endtask

    task automatic gen(input int cnt);
        words.delete();
        for (int i = 0; i < cnt; i++) words.push_back(24'($urandom));
    endtask

    task automatic send(input logic s, input int l, input logic [23:0] d[$]);
        for (int i = 0; i < d.size(); i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_sof = i == 0;
            bus.rx_eof = i == d.size() - 1;
            bus.rx_data = d[i];
            bus.sel_byte = i == 0 ? s : ~s;
            bus.rx_len = i == 0 ? 16'(l) : 16'($urandom);
            if (i == 0) sof_cyc = cyc;
            tick();
        end
        bus.rx_valid = 1'b0;
        bus.rx_sof = 1'b0;
        bus.rx_eof = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (q_d.size() == 0 && k < budget) begin
            tick();
            k++;
        end
        check({tag, "_done_seen"}, 64'(q_d.size() != 0), 64'd1);
    endtask

    task automatic clear_errs();
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
    endtask

    // Model: byte sink sees the stored words flattened MSB-first, cut to the frame length;
    // word sink sees every stored word with last on the final one.
    task automatic expect_frame(input string tag, input logic s, input int l, input logic [23:0] w[$]);
        logic [8:0] eb[$];
        logic [24:0] ew[$];
        int exp_cnt;
        foreach (w[i]) for (int b = 2; b >= 0; b--) eb.push_back({1'b0, w[i][8*b +: 8]});
        foreach (w[i]) ew.push_back({i == w.size() - 1, w[i]});
        while (eb.size() > l) void'(eb.pop_back());
        if (eb.size() != 0) eb[eb.size()-1][8] = 1'b1;
        if (!s) eb.delete();
        else ew.delete();
        exp_cnt = s ? eb.size() : ew.size();
        check({tag, "_count"}, 64'(q_d.size() != 0 ? q_d[0] : 16'hffff), 64'(exp_cnt));
        check({tag, "_nbytes"}, 64'(q_b.size()), 64'(eb.size()));
        check({tag, "_nwords"}, 64'(q_w.size()), 64'(ew.size()));
        for (int i = 0; i < eb.size() && i < q_b.size(); i++) check({tag, "_byte"}, 64'(q_b[i]), 64'(eb[i]));
        for (int i = 0; i < ew.size() && i < q_w.size(); i++) check({tag, "_word"}, 64'(q_w[i]), 64'(ew[i]));
        check({tag, "_len_err"}, 64'(bus.len_err), 64'(s && l > 3 * w.size()));
        q_b.delete();
        q_w.delete();
        if (q_d.size() != 0) void'(q_d.pop_front());
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_sof = 1'b0;
        bus.rx_eof = 1'b0;
        bus.rx_data = '0;
        bus.rx_len = '0;
        bus.sel_byte = 1'b0;
        bus.err_clr = 1'b0;
        bus.byte_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", outs(), 64'd0);
        reset_n = 1'b1;
        tick();

        // Byte mode, len 7 over three words: padding C2/C3 stripped, two-cycle latency
        words = '{24'hA1A2A3, 24'hB1B2B3, 24'hC1C2C3};
        first_cyc = -1;
        send(1'b1, 7, words);
        wait_done("t1", 100);
        check("t1_latency", 64'(first_cyc - sof_cyc), 64'd2);
        expect_frame("t1", 1'b1, 7, words);
        check("t1_overflow", 64'(bus.overflow), 64'd0);

        // Word mode, 4 words as back-to-back strobes
        gen(4);
        first_cyc = -1;
        send(1'b0, int'($urandom_range(0, 100)), words);
        wait_done("t2", 100);
        check("t2_latency", 64'(first_cyc - sof_cyc), 64'd2);
        check("t2_back_to_back", 64'(last_w_cyc - first_cyc), 64'd3);
        expect_frame("t2", 1'b0, 0, words);

        // Byte mode with toggling ready, 16-word frame must not lose anything
        rdy_mode = 1;
        gen(16);
        send(1'b1, 48, words);
        wait_done("t3", 400);
        expect_frame("t3", 1'b1, 48, words);
        check("t3_overflow", 64'(bus.overflow), 64'd0);

        // Stalled sink, 20-word frame: 16 kept, rest dropped, frame cut at the 16th word
        rdy_mode = 3;
        bus.byte_ready = 1'b0;
        gen(20);
        len = int'($urandom_range(30, 60));
        send(1'b1, len, words);
        repeat (4) tick();
        check("t4_overflow_set", 64'(bus.overflow), 64'd1);
        check("t4_nothing_out", 64'(q_b.size()), 64'd0);
        saved.delete();
        for (int i = 0; i < 16; i++) saved.push_back(words[i]);
        rdy_mode = 0;
        wait_done("t4", 300);
        expect_frame("t4", 1'b1, len, saved);
        clear_errs();
        check("t4_err_clr", 64'({bus.overflow, bus.len_err}), 64'd0);

        // Length longer than the words received
        rdy_mode = 2;
        gen(2);
        send(1'b1, 9, words);
        wait_done("t5", 100);
        expect_frame("t5", 1'b1, 9, words);
        check("t5_overflow", 64'(bus.overflow), 64'd0);
        clear_errs();

        // A new sof while the previous frame still drains is dropped whole
        rdy_mode = 0;
        gen(6);
        saved = words;
        send(1'b0, 0, saved);
        gen(3);
        send(1'b1, 9, words);
        wait_done("t6", 100);
        expect_frame("t6", 1'b0, 0, saved);
        repeat (30) tick();
        check("t6_no_output", 64'(q_b.size() + q_w.size() + q_d.size()), 64'd0);
        check("t6_overflow", 64'(bus.overflow), 64'd1);
        clear_errs();

        // Reset mid-frame, then a clean frame
        gen(3);
        bus.rx_valid = 1'b1;
        bus.sel_byte = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.rx_sof = i == 0;
            bus.rx_data = words[i];
            bus.rx_len = 16'd40;
            tick();
        end
        check("t7_active_before_reset", 64'(bus.word_valid), 64'd1);
        bus.rx_valid = 1'b0;
        bus.rx_sof = 1'b0;
        reset_n = 1'b0;
        #1;
        check("t7_reset_outputs", outs(), 64'd0);
        tick();
        reset_n = 1'b1;
        q_b.delete();
        q_w.delete();
        q_d.delete();
        tick();
        gen(5);
        send(1'b1, 14, words);
        wait_done("t7", 100);
        expect_frame("t7", 1'b1, 14, words);

        // Randomized frames against the model
        for (int f = 0; f < 12; f++) begin
            sel = 1'($urandom);
            n = int'($urandom_range(1, 12));
            len = int'($urandom_range(0, 3 * n + 4));
            rdy_mode = int'($urandom_range(0, 2));
            clear_errs();
            tick();
            gen(n);
            send(sel, len, words);
            wait_done("rnd", n * 12 + 60);
            expect_frame("rnd", sel, len, words);
            check("rnd_overflow", 64'(bus.overflow), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/udp_rx_demux_unpack.md
Name: udp_rx_demux_unpack

Overview:
- Receive-side counterpart of the UDP TX source mux.
- Takes 24-bit words from the UDP receive module, buffers them in a small word FIFO, and routes each frame to one of two sinks:
  - an 8-bit byte stream, unpacked MSB-first, with padding stripped using the frame byte length;
  - a 24-bit word pass-through stream.
- Sits between the UDP RX engine and the SD/TF writer or SDRAM frame writer.

Parameters:
- FIFO_AW, 4, log2 of word FIFO depth (16 entries).
- LEN_W, 16, width of the byte-length and word-count fields.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- sel_byte  in  1  sink select, sampled at SOF: 1 = byte sink, 0 = word sink
- rx_data  in  24  received word, MSB byte first on the wire
- rx_valid  in  1  rx_data valid; no backpressure possible
- rx_sof  in  1  qualifies the first word of a frame; only meaningful with rx_valid
- rx_eof  in  1  qualifies the last word of a frame; only meaningful with rx_valid
- rx_len  in  LEN_W  frame length in bytes; valid with rx_sof
- byte_data  out  8  unpacked byte
- byte_valid  out  1  byte_data valid
- byte_ready  in  1  byte sink ready
- byte_last  out  1  last payload byte of the frame
- word_data  out  24  pass-through word
- word_valid  out  1  one-cycle strobe; no ready
- word_last  out  1  last word of the frame
- frame_done  out  1  one-cycle pulse when the frame has fully drained
- frame_count  out  LEN_W  words (word mode) or bytes (byte mode) delivered; valid with frame_done
- overflow  out  1  sticky: word dropped on FIFO full or frame rejected
- len_err  out  1  sticky: rx_len exceeded 3 × words received
- err_clr  in  1  synchronous clear of overflow and len_err

Behaviour:
- Reset: all outputs 0, FIFO empty, FSM in IDLE. Reset mid-frame discards all state.
- FIFO entry: {sof, eof, data[23:0]}.
- Write rule: write when rx_valid and the frame is accepted.
  - Full: drop the word, set overflow, mark the frame truncated. A forced eof is applied to the last stored entry only if that entry is not yet read; otherwise the current frame terminates on read of the next sof.
- Frame acceptance:
  - An rx_sof word is accepted only if the FSM is IDLE and the FIFO is empty. sel_byte and rx_len are latched into mode_r / len_r at that moment.
  - Otherwise the whole frame, through rx_eof, is dropped and overflow is set.
- Read side: registered read, so the first output appears 2 cycles after the word is written.
- FSM states and transitions:
  - IDLE: waits for FIFO non-empty → WORD or B0 by mode_r.
  - WORD: pops one entry per cycle while non-empty.
    - word_valid = 1, word_data = entry, word_last = eof.
    - Counter increments per word.
    - On eof → DONE.
  - B0/B1/B2: emit byte_data = data[23:16], [15:8], [7:0] respectively.
    - Advance only on byte_valid & byte_ready.
    - byte_valid held with byte_data stable until accepted.
    - Pop the next entry when leaving B2.
    - rem (bytes remaining, loaded from len_r) decrements per accepted byte.
    - When rem == 1, byte_last = 1; on acceptance → DRAIN.
  - DRAIN: pops and discards entries until the eof entry has been popped → DONE. If the eof entry was already popped, go straight to DONE.
  - DONE: one cycle.
    - frame_done = 1.
    - frame_count = delivered count (LEN_W, wraps).
    - Counter cleared → IDLE.
- rx_len == 0 in byte mode: no bytes emitted; go directly to DRAIN.
- eof reached in byte mode with rem > bytes of the current word:
  - The last byte of that word is emitted with byte_last = 1.
  - len_err is set → DONE.
- Simultaneous events:
  - rx_sof & rx_eof on the same word is a one-word frame.
  - Simultaneous set and err_clr: set wins.
- sel_byte changes mid-frame are ignored.

Decomposition:
- Shared package udp_pkg: UDP_WORD_W = 24, BYTES_PER_WORD = 3, LEN_W default, FSM state enum.
- Sub-module sync_fifo_fwft (parameters WIDTH = 26, AW = FIFO_AW) holds the buffer.
- FSM and unpacker live in the top.

Test Plan:
- Byte mode, rx_len = 7, three words 0xA1A2A3 0xB1B2B3 0xC1C2C3, byte_ready = 1 → bytes A1 A2 A3 B1 B2 B3 C1; byte_last on C1; C2/C3 dropped; frame_done with frame_count = 7; first byte_valid 2 cycles after the first word.
- Word mode, 4 words → 4 consecutive word_valid strobes carrying the same data; word_last on the 4th; frame_count = 4.
- Byte mode, byte_ready toggling 1-0-1-0 → byte_data stable while stalled; byte order unchanged; no FIFO loss for a 16-word frame.
- byte_ready = 0 for a 20-word frame, FIFO_AW = 4 → 16 stored, 4 dropped; overflow = 1; next sof accepted after drain; err_clr clears it.
- Byte mode, rx_len = 9 with 2 words → 6 bytes, byte_last on the 6th; len_err = 1; frame_count = 6.
- rx_sof arriving while the previous frame is still draining → whole frame dropped; overflow = 1; no output for it. Also: reset_n asserted mid-frame → all outputs 0 next edge; the following frame decodes cleanly.
